serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_sub_pkg.sv | 13 +
 rtl/serial_subtractor_full_subtractor.sv | 14 +
 rtl/serial_subtractor.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: D = A - B - Bin, Bout is the borrow out.
// Purely combinational; the serial datapath reuses a single instance.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    assign D    = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes Diff = A - B - Bin (mod 2^WIDTH) one bit
// per clock, LSB first, and reports the final borrow in Bout.
// Optional feature: define SERIAL_SUB_OVERFLOW_EN to add output V, the
// registered two's-complement overflow flag of the result.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             V
`endif
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;      // minuend, shifted right one bit per RUN edge
    logic [WIDTH-1:0] b_sh_r;      // subtrahend, shifted alongside
    logic [WIDTH-1:0] res_r;       // partial result, filled from the MSB side
    logic [CNT_W-1:0] cnt_r;       // RUN edges already taken
    logic             br_r;        // running borrow
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             a_msb_r;     // operand sign bits kept for the overflow flag,
    logic             b_msb_r;     // since the shift registers lose them
    logic             v_r;
`endif

    logic             d_s;
    logic             br_next_s;
    logic [WIDTH-1:0] res_next_s;
    logic             last_s;

    full_subtractor u_full_subtractor (
        .A    (a_sh_r[0]),
        .B    (b_sh_r[0]),
        .Bin  (br_r),
        .D    (d_s),
        .Bout (br_next_s)
    );

    // Shift the new difference bit into the top of the partial result; after
    // WIDTH shifts the result is aligned without a final correction step.
    always_comb begin
        res_next_s            = res_r >> 1'b1;
        res_next_s[WIDTH-1]   = d_s;
        last_s                = (cnt_r == LAST_CNT);
    end

    // Control FSM and serial datapath; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            br_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            diff_r  <= {WIDTH{1'b0}};
            bout_r  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            v_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_sh_r  <= A;
                        b_sh_r  <= B;
                        br_r    <= Bin;
                        res_r   <= {WIDTH{1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
`ifdef SERIAL_SUB_OVERFLOW_EN
                        a_msb_r <= A[WIDTH-1];
                        b_msb_r <= B[WIDTH-1];
`endif
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                RUN: begin
                    // start is deliberately not looked at here
                    a_sh_r <= a_sh_r >> 1'b1;
                    b_sh_r <= b_sh_r >> 1'b1;
                    br_r   <= br_next_s;
                    res_r  <= res_next_s;
                    cnt_r  <= cnt_r + CNT_ONE;
                    if (last_s) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        diff_r  <= res_next_s;
                        bout_r  <= br_next_s;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        v_r     <= (a_msb_r ^ b_msb_r) & (a_msb_r ^ res_next_s[WIDTH-1]);
`endif
                    end else begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign Diff = diff_r;
    assign Bout = bout_r;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign V    = v_r;
`endif

endmodule
